// File: rtl/uart_pkg.sv
// Shared definitions for the queued UART transmitter: parity modes,
// FSM state encoding and the parity helper.
package uart_pkg;

  localparam int UART_PAR_NONE = 0;
  localparam int UART_PAR_ODD  = 1;
  localparam int UART_PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOPB
  } uart_state_e;

  // Data is zero-extended to 8 bits by the caller; the padding does not disturb the XOR.
  function automatic logic uart_par(input logic [7:0] data, input int mode);
    case (mode)
      UART_PAR_ODD:  return ~(^data);
      UART_PAR_EVEN: return ^data;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers for full/empty and a registered
// occupancy count.
module uart_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  // Full blocks a push even when a pop lands on the same edge.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign level    = count;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_txq.sv
// UART transmitter fed by a word queue: configurable frame format, run-time
// baud period and clear-to-send gating of each frame start.
module uart_txq
  import uart_pkg::*;
#(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic [15:0]              tx_div,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     cts_n,
  output logic                     txd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam bit HAS_PAR = (PARITY != UART_PAR_NONE);

  uart_state_e   state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [15:0]   period_q, period_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          stop_cnt_q, stop_cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          pop;
  logic          launch;
  logic          tick;
  logic          start_ok;
  logic [15:0]   eff_div;

  uart_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign txd      = txd_q;
  assign eff_div  = (tx_div < 16'd2) ? 16'd2 : tx_div;
  assign tick     = (timer_q == 16'd0);
  assign start_ok = !fifo_empty && !cts_n;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      period_q   <= 16'd2;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
    end
  end

  // txd is registered, so each branch sets the level the line takes after this edge.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    txd_d      = txd_q;
    pop        = 1'b0;
    launch     = 1'b0;
    timer_d    = timer_q;

    if (state_q != ST_IDLE) begin
      timer_d = tick ? (period_q - 16'd1) : (timer_q - 16'd1);
    end

    case (state_q)
      ST_IDLE: begin
        launch = start_ok;
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'(DW - 1);
          txd_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd0) begin
            if (HAS_PAR) begin
              state_d = ST_PAR;
              txd_d   = par_q;
            end else begin
              state_d    = ST_STOPB;
              stop_cnt_d = 1'(STOP - 1);
              txd_d      = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      ST_PAR: begin
        if (tick) begin
          state_d    = ST_STOPB;
          stop_cnt_d = 1'(STOP - 1);
          txd_d      = 1'b1;
        end
      end
      ST_STOPB: begin
        if (tick) begin
          if (stop_cnt_q == 1'b0) begin
            if (start_ok) begin
              launch = 1'b1;
            end else begin
              state_d = ST_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            stop_cnt_d = stop_cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Frame start: the period is latched here so tx_div changes wait for the next frame.
    if (launch) begin
      pop      = 1'b1;
      state_d  = ST_START;
      shift_d  = fifo_data;
      par_d    = uart_par(8'(fifo_data), PARITY);
      period_d = eff_div;
      timer_d  = eff_div - 16'd1;
      txd_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_txq.sv
// Directed bench for uart_txq: an 8N1 instance and a 7E2 instance sharing
// clock, reset and tx_div.
module tb_uart_txq;

  logic        clk;
  logic        rst_n;
  logic [15:0] tx_div;

  logic [7:0]  a_data;
  logic        a_valid;
  logic        a_ready;
  logic        a_cts_n;
  logic        a_txd;
  logic [4:0]  a_level;
  logic        a_busy;

  logic [6:0]  b_data;
  logic        b_valid;
  logic        b_ready;
  logic        b_cts_n;
  logic        b_txd;
  logic [4:0]  b_level;
  logic        b_busy;

  int tests = 0;
  int fails = 0;

  uart_txq #(.DW(8), .DEPTH(16), .PARITY(0), .STOP(1)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .tx_div   (tx_div),
    .in_data  (a_data),
    .in_valid (a_valid),
    .in_ready (a_ready),
    .cts_n    (a_cts_n),
    .txd      (a_txd),
    .level    (a_level),
    .busy     (a_busy)
  );

  uart_txq #(.DW(7), .DEPTH(16), .PARITY(2), .STOP(2)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .tx_div   (tx_div),
    .in_data  (b_data),
    .in_valid (b_valid),
    .in_ready (b_ready),
    .cts_n    (b_cts_n),
    .txd      (b_txd),
    .level    (b_level),
    .busy     (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    a_data  = w;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
  endtask

  // Bit 0 is the start bit; each entry is held for p cycles starting at the current cycle.
  task automatic expectFrame(input string tag, input int which, input logic [15:0] bits,
                             input int nbits, input int p);
    logic obs;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < p; j++) begin
        obs = (which != 0) ? b_txd : a_txd;
        checkOutput(tag, 32'(obs), 32'(bits[i]));
        tick();
      end
    end
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] w);
    return {6'b0, 1'b1, w, 1'b0};
  endfunction

  function automatic logic [15:0] frame7e2(input logic [6:0] w);
    return {5'b0, 2'b11, ^w, w, 1'b0};
  endfunction

  logic [7:0] words [16];

  initial begin
    rst_n   = 1'b0;
    tx_div  = 16'd4;
    a_data  = '0;
    a_valid = 1'b0;
    a_cts_n = 1'b0;
    b_data  = '0;
    b_valid = 1'b0;
    b_cts_n = 1'b0;
    tick();
    tick();
    checkOutput("rst_txd", 32'(a_txd), 32'd1);
    checkOutput("rst_level", 32'(a_level), 32'd0);
    checkOutput("rst_busy", 32'(a_busy), 32'd0);
    checkOutput("rst_ready", 32'(a_ready), 32'd1);
    checkOutput("rst_txd_b", 32'(b_txd), 32'd1);
    rst_n = 1'b1;
    tick();

    // 0x55, 8N1, P=4: start bit one edge after the push, 40-cycle frame
    applyStimulus(8'h55);
    checkOutput("push_level", 32'(a_level), 32'd1);
    checkOutput("push_txd_idle", 32'(a_txd), 32'd1);
    checkOutput("push_busy", 32'(a_busy), 32'd1);
    tick();
    checkOutput("pop_level", 32'(a_level), 32'd0);
    expectFrame("f55", 0, frame8(8'h55), 10, 4);
    checkOutput("f55_busy_end", 32'(a_busy), 32'd0);
    checkOutput("f55_txd_end", 32'(a_txd), 32'd1);

    // 0x03 on 7E2: 0 1100000 0 11
    b_data  = 7'h03;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    tick();
    expectFrame("f03_7e2", 1, 16'b000_0_11_0_0000011_0, 11, 4);
    checkOutput("f03_busy_end", 32'(b_busy), 32'd0);

    // Fill past capacity with cts_n held high, then drain back-to-back
    tx_div  = 16'd2;
    a_cts_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      checkOutput("fill_ready", 32'(a_ready), (i < 16) ? 32'd1 : 32'd0);
      applyStimulus(8'(i * 37 + 11));
      if (i < 16) words[i] = 8'(i * 37 + 11);
    end
    checkOutput("full_level", 32'(a_level), 32'd16);
    checkOutput("full_ready", 32'(a_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("cts_hold_txd", 32'(a_txd), 32'd1);
      tick();
    end
    a_cts_n = 1'b0;
    tick();
    checkOutput("drain_level", 32'(a_level), 32'd15);
    for (int i = 0; i < 16; i++) begin
      expectFrame("drain_frame", 0, frame8(words[i]), 10, 2);
    end
    checkOutput("drain_busy", 32'(a_busy), 32'd0);
    checkOutput("drain_level_end", 32'(a_level), 32'd0);

    // cts_n raised mid-frame: frame completes, next start waits
    a_data  = 8'hC3;
    a_valid = 1'b1;
    tick();
    a_data  = 8'h3C;
    tick();
    a_valid = 1'b0;
    a_cts_n = 1'b1;
    expectFrame("cts_frame", 0, frame8(8'hC3), 10, 2);
    for (int i = 0; i < 6; i++) begin
      checkOutput("cts_wait_txd", 32'(a_txd), 32'd1);
      tick();
    end
    checkOutput("cts_wait_level", 32'(a_level), 32'd1);
    checkOutput("cts_wait_busy", 32'(a_busy), 32'd1);
    a_cts_n = 1'b0;
    tick();
    expectFrame("cts_next", 0, frame8(8'h3C), 10, 2);
    checkOutput("cts_busy_end", 32'(a_busy), 32'd0);

    // Reset during DATA with 5 words still queued
    a_cts_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(8'(8'hF0 + i));
    a_cts_n = 1'b0;
    tick();
    checkOutput("mid_level", 32'(a_level), 32'd5);
    tick();
    tick();
    tick();
    checkOutput("mid_data_bit0", 32'(a_txd), 32'd0);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_txd", 32'(a_txd), 32'd1);
    checkOutput("mid_rst_level", 32'(a_level), 32'd0);
    checkOutput("mid_rst_busy", 32'(a_busy), 32'd0);
    checkOutput("mid_rst_ready", 32'(a_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    applyStimulus(8'hA5);
    tick();
    expectFrame("post_rst", 0, frame8(8'hA5), 10, 2);

    // Periods below 2 clamp to 2
    tx_div = 16'd0;
    applyStimulus(8'h81);
    tick();
    expectFrame("div0", 0, frame8(8'h81), 10, 2);
    tx_div = 16'd1;
    applyStimulus(8'h7E);
    tick();
    expectFrame("div1", 0, frame8(8'h7E), 10, 2);

    // tx_div changed during a frame applies from the next start bit
    tx_div  = 16'd3;
    a_data  = 8'h96;
    a_valid = 1'b1;
    tick();
    a_data  = 8'h69;
    tick();
    a_valid = 1'b0;
    tx_div  = 16'd5;
    expectFrame("div_old", 0, frame8(8'h96), 10, 3);
    expectFrame("div_new", 0, frame8(8'h69), 10, 5);
    checkOutput("div_busy_end", 32'(a_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
